execute_load_store_req: RTL
===========================

// Module: execute_load_store_req
// PURPOSE
//  Load/store request sequencer in the execute stage, directly upstream of the load-data alignment stage.
//  Takes one load/store command, checks alignment, builds the big-endian byte mask and the aligned store data,
//  and runs the data-memory request/response handshake.
//  Hands the raw 32-bit load word plus mask/shift to the alignment stage; reports faults instead of accessing memory.
// PARAMETERS
//  P_TIMEOUT  255  max cycles in WAIT for iDATAIO_VALID before timeout fault (1..65535)
// PORTS
//  iCLOCK          in   1   clock
//  inRESET         in   1   asynchronous active-low reset
//  iEVENT_FLUSH    in   1   pipeline flush; aborts the current command
//  iEXE_VALID      in   1   command valid; accepted when oEXE_BUSY=0
//  oEXE_BUSY       out  1   sequencer not in IDLE
//  iEXE_LOAD       in   1   1=load, 0=store
//  iEXE_SIZE       in   2   0=byte, 1=halfword, 2=word (3 reserved -> align fault)
//  iEXE_ADDR       in   32  byte address
//  iEXE_DATA       in   32  store data, right-justified
//  iEXE_DEST       in   5   load destination register
//  oDATAIO_REQ     out  1   memory request valid; held until accepted (iDATAIO_BUSY=0)
//  iDATAIO_BUSY    in   1   memory cannot accept
//  oDATAIO_RW      out  1   1=write, 0=read
//  oDATAIO_ADDR    out  32  word address {addr[31:2],2'b00}
//  oDATAIO_MASK    out  4   byte enables
//  oDATAIO_DATA    out  32  positioned store data
//  iDATAIO_VALID   in   1   response valid (one per request, reads and writes)
//  iDATAIO_DATA    in   32  read word
//  oLDST_VALID     out  1   result valid; held until !iLDST_BUSY
//  iLDST_BUSY      in   1   downstream stall
//  oLDST_LOAD      out  1   result belongs to a load
//  oLDST_MASK      out  4   mask of the access
//  oLDST_SHIFT     out  2   addr[1:0] of the access
//  oLDST_DATA      out  32  raw memory word (0 for stores)
//  oLDST_DEST      out  5   destination register
//  oFAULT_ALIGN    out  1   one-cycle pulse: misaligned/reserved-size command dropped
//  oFAULT_TIMEOUT  out  1   one-cycle pulse: response not received in P_TIMEOUT cycles
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; timeout counter 0; command registers 0.
//  - Mask (big-endian, offset 0 = bits[31:24]): byte off0..3 -> 0001/0010/0100/1000;
//    half off0 -> 0011, off2 -> 1100; word -> 1111. Store data: byte off n -> data[7:0] at bits[31-8n:24-8n],
//    half off0 -> [31:16], off2 -> [15:0]; unused lanes 0.
//  - Align fault: half with addr[0]=1, word with addr[1:0]!=0, or size 3 -> oFAULT_ALIGN pulse the cycle after
//    acceptance, stay IDLE, no memory request, no oLDST_VALID.
//  - FSM IDLE->REQ on accept (all command fields registered). REQ: oDATAIO_REQ=1, address/mask/data/rw stable;
//    on !iDATAIO_BUSY -> WAIT next cycle. WAIT: counter increments per cycle; iDATAIO_VALID -> capture data,
//    go DONE. DONE: oLDST_VALID=1, outputs stable; on !iLDST_BUSY -> IDLE next cycle.
//  - Minimum latency accept->oLDST_VALID: 3 cycles (REQ accepted 1st cycle, response 1 cycle later).
//  - oEXE_BUSY=0 only in IDLE; a new command can be accepted the cycle after DONE clears.
//  - Timeout: counter reaches P_TIMEOUT in WAIT -> oFAULT_TIMEOUT pulse, -> DRAIN. Response and timeout in
//    same cycle: response wins.
//  - Flush: IDLE/REQ/DONE -> IDLE next cycle, request dropped, no result. WAIT -> DRAIN.
//    DRAIN: discard next iDATAIO_VALID, then IDLE; oEXE_BUSY=1 throughout. Flush in DRAIN: no effect.
//  - Flush in same cycle as iEXE_VALID in IDLE: command not accepted.
//  - iDATAIO_VALID outside WAIT/DRAIN: ignored.
//  - Reset mid-operation: immediate return to IDLE, all outputs 0; outstanding response is ignored.
// TESTING
//  - Load word addr 0x100, mem returns 0xDEADBEEF -> REQ rw=0 addr 0x100 mask 1111; LDST data 0xDEADBEEF shift 0.
//  - Store byte 0x5A at addr 0x203 -> addr 0x200 mask 1000 data 0x0000005A; LDST_VALID with LOAD=0.
//  - Load half addr 0x101 -> oFAULT_ALIGN pulse, no oDATAIO_REQ, BUSY low next cycle.
//  - iDATAIO_BUSY=1 for 4 cycles then 0, iLDST_BUSY=1 for 2 cycles -> REQ fields held; LDST outputs held.
//  - Flush in WAIT, response 3 cycles later -> no LDST_VALID, response discarded, IDLE after it.
//  - P_TIMEOUT=8, no response -> oFAULT_TIMEOUT after 8 WAIT cycles, DRAIN until a response arrives.

Source files
------------

// File: rtl/execute_load_store_req.sv
// ============================================================================
// Module   : execute_load_store_req
// Purpose  : Execute-stage load/store sequencer. It accepts one command and
//            checks its alignment. It builds the big-endian byte mask and the
//            positioned store data, runs the data-memory request/response
//            handshake and hands the raw word to the alignment stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_load_store_req #(
    parameter int P_TIMEOUT = 255
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iEVENT_FLUSH,
    input  logic        iEXE_VALID,
    output logic        oEXE_BUSY,
    input  logic        iEXE_LOAD,
    input  logic [1:0]  iEXE_SIZE,
    input  logic [31:0] iEXE_ADDR,
    input  logic [31:0] iEXE_DATA,
    input  logic [4:0]  iEXE_DEST,
    output logic        oDATAIO_REQ,
    input  logic        iDATAIO_BUSY,
    output logic        oDATAIO_RW,
    output logic [31:0] oDATAIO_ADDR,
    output logic [3:0]  oDATAIO_MASK,
    output logic [31:0] oDATAIO_DATA,
    input  logic        iDATAIO_VALID,
    input  logic [31:0] iDATAIO_DATA,
    output logic        oLDST_VALID,
    input  logic        iLDST_BUSY,
    output logic        oLDST_LOAD,
    output logic [3:0]  oLDST_MASK,
    output logic [1:0]  oLDST_SHIFT,
    output logic [31:0] oLDST_DATA,
    output logic [4:0]  oLDST_DEST,
    output logic        oFAULT_ALIGN,
    output logic        oFAULT_TIMEOUT
);

    // Last WAIT count before the timeout fires; the counter starts at 0 on WAIT entry.
    localparam logic [15:0] TIMEOUT_LAST = 16'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;

    logic        accept;
    logic        misalign;
    logic [3:0]  cmd_mask;
    logic [31:0] cmd_data;

    assign accept    = (state == ST_IDLE) && iEXE_VALID && !iEVENT_FLUSH;
    assign oEXE_BUSY = (state != ST_IDLE);

    // Alignment check, byte-lane mask and positioned store data for the incoming command.
    always_comb begin
        misalign = 1'b0;
        cmd_mask = 4'b0000;
        cmd_data = 32'h0000_0000;
        case (iEXE_SIZE)
            2'd0: begin
                case (iEXE_ADDR[1:0])
                    2'd0: begin cmd_mask = 4'b0001; cmd_data = {iEXE_DATA[7:0], 24'h0}; end
                    2'd1: begin cmd_mask = 4'b0010; cmd_data = {8'h0, iEXE_DATA[7:0], 16'h0}; end
                    2'd2: begin cmd_mask = 4'b0100; cmd_data = {16'h0, iEXE_DATA[7:0], 8'h0}; end
                    default: begin cmd_mask = 4'b1000; cmd_data = {24'h0, iEXE_DATA[7:0]}; end
                endcase
            end
            2'd1: begin
                misalign = iEXE_ADDR[0];
                if (iEXE_ADDR[1]) begin
                    cmd_mask = 4'b1100;
                    cmd_data = {16'h0, iEXE_DATA[15:0]};
                end else begin
                    cmd_mask = 4'b0011;
                    cmd_data = {iEXE_DATA[15:0], 16'h0};
                end
            end
            2'd2: begin
                misalign = (iEXE_ADDR[1:0] != 2'b00);
                cmd_mask = 4'b1111;
                cmd_data = iEXE_DATA;
            end
            default: misalign = 1'b1;
        endcase
        // Loads drive no write data onto the memory bus.
        if (iEXE_LOAD) begin
            cmd_data = 32'h0000_0000;
        end
    end

    // Sequencer FSM with registered memory-side and result-side outputs.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state          <= ST_IDLE;
            wait_cnt       <= 16'h0000;
            oDATAIO_REQ    <= 1'b0;
            oDATAIO_RW     <= 1'b0;
            oDATAIO_ADDR   <= 32'h0000_0000;
            oDATAIO_MASK   <= 4'b0000;
            oDATAIO_DATA   <= 32'h0000_0000;
            oLDST_VALID    <= 1'b0;
            oLDST_LOAD     <= 1'b0;
            oLDST_MASK     <= 4'b0000;
            oLDST_SHIFT    <= 2'b00;
            oLDST_DATA     <= 32'h0000_0000;
            oLDST_DEST     <= 5'd0;
            oFAULT_ALIGN   <= 1'b0;
            oFAULT_TIMEOUT <= 1'b0;
        end else begin
            oFAULT_ALIGN   <= 1'b0;
            oFAULT_TIMEOUT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            oFAULT_ALIGN <= 1'b1;
                        end else begin
                            state        <= ST_REQ;
                            oDATAIO_REQ  <= 1'b1;
                            oDATAIO_RW   <= !iEXE_LOAD;
                            oDATAIO_ADDR <= {iEXE_ADDR[31:2], 2'b00};
                            oDATAIO_MASK <= cmd_mask;
                            oDATAIO_DATA <= cmd_data;
                            oLDST_LOAD   <= iEXE_LOAD;
                            oLDST_MASK   <= cmd_mask;
                            oLDST_SHIFT  <= iEXE_ADDR[1:0];
                            oLDST_DEST   <= iEXE_DEST;
                        end
                    end
                end
                ST_REQ: begin
                    if (iEVENT_FLUSH) begin
                        state       <= ST_IDLE;
                        oDATAIO_REQ <= 1'b0;
                    end else if (!iDATAIO_BUSY) begin
                        state       <= ST_WAIT;
                        oDATAIO_REQ <= 1'b0;
                        wait_cnt    <= 16'h0000;
                    end
                end
                ST_WAIT: begin
                    if (iEVENT_FLUSH) begin
                        // A response landing with the flush is consumed here, so nothing is left to drain.
                        state <= iDATAIO_VALID ? ST_IDLE : ST_DRAIN;
                    end else if (iDATAIO_VALID) begin
                        state       <= ST_DONE;
                        oLDST_VALID <= 1'b1;
                        oLDST_DATA  <= oLDST_LOAD ? iDATAIO_DATA : 32'h0000_0000;
                    end else if (wait_cnt >= TIMEOUT_LAST) begin
                        state          <= ST_DRAIN;
                        oFAULT_TIMEOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'h0001;
                    end
                end
                ST_DONE: begin
                    if (iEVENT_FLUSH || !iLDST_BUSY) begin
                        state       <= ST_IDLE;
                        oLDST_VALID <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (iDATAIO_VALID) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    oDATAIO_REQ <= 1'b0;
                    oLDST_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
